if_fetch_queue: RTL and testbench

//  Instruction-fetch stage directly upstream of IF/ID -> ID. Generates sequential fetch PCs, requests

---
 rtl/if_fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// ============================================================================
// if_fetch_queue: sequential-PC fetch over a req/ack memory port, buffered in
// a small FIFO for IF/ID. Optional JAL_PREDICT_EN macro. Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_o,
  output logic        inst_pred_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        pc_mem_q  [QUEUE_DEPTH];
  logic [31:0]        ins_mem_q [QUEUE_DEPTH];

  logic [31:0] w_jump_tgt;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_bits;

  assign w_jump_tgt    = {jump_addr_i[31:2], 2'b00};
  assign w_unused_bits = ^jump_addr_i[1:0];
  assign w_seq_pc      = mem_addr_q + 32'd4;
  assign w_push        = (state_q == ST_WAIT) && mem_ack_i && !jump_i;
  assign w_pop         = inst_valid_o && !stall_i && !jump_i;

`ifdef JAL_PREDICT_EN
  logic        pred_mem_q [QUEUE_DEPTH];
  logic        w_is_jal;
  logic [31:0] w_j_imm;

  assign w_is_jal  = (mem_data_i[6:0] == 7'b1101111);
  assign w_j_imm   = {{12{mem_data_i[31]}}, mem_data_i[19:12], mem_data_i[20],
                      mem_data_i[30:21], 1'b0};
  assign w_next_pc = w_is_jal ? ((mem_addr_q + w_j_imm) & 32'hFFFF_FFFC) : w_seq_pc;
  assign inst_pred_o = pred_mem_q[rd_ptr_q];
`else
  assign w_next_pc   = w_seq_pc;
  assign inst_pred_o = 1'b0;
`endif

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];
  assign inst_o       = ins_mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (jump_i) begin
          fetch_pc_d = w_jump_tgt;
        end else if (count_q < CNT_W'(QUEUE_DEPTH)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {fetch_pc_q[31:2], 2'b00};
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (jump_i) begin
          fetch_pc_d = w_jump_tgt;
          if (mem_ack_i) begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_DROP;
          end
        end else if (mem_ack_i) begin
          fetch_pc_d = w_next_pc;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (jump_i) begin
          fetch_pc_d = w_jump_tgt;
        end
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Draining the last entry parks both pointers on it so the head keeps its value.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        ins_mem_q[i]  <= '0;
`ifdef JAL_PREDICT_EN
        pred_mem_q[i] <= 1'b0;
`endif
      end
    end else if (jump_i) begin
      count_q  <= '0;
      wr_ptr_q <= rd_ptr_q;
    end else begin
      if (w_push) begin
        pc_mem_q[wr_ptr_q]   <= mem_addr_q;
        ins_mem_q[wr_ptr_q]  <= mem_data_i;
`ifdef JAL_PREDICT_EN
        pred_mem_q[wr_ptr_q] <= w_is_jal;
`endif
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        if (!w_push && (count_q == CNT_W'(1))) begin
          wr_ptr_q <= rd_ptr_q;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
      count_q <= count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// tb_if_fetch_queue: directed bench for if_fetch_queue with a 2-cycle memory.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [31:0] jump_addr;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_o;
  logic        inst_pred_o;

  int          vectors;
  int          miscompares;
  int          cnt;
  bit          ok;
  logic [31:0] req_log [$];
  logic [31:0] pop_log [$];

  if_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .stall_i      (stall),
    .jump_i       (jump),
    .jump_addr_i  (jump_addr),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data),
    .inst_valid_o (inst_valid_o),
    .inst_pc_o    (inst_pc_o),
    .inst_o       (inst_o),
    .inst_pred_o  (inst_pred_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h20) ? 32'h0100_006F : {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Memory answers each request two edges after it is issued.
  task automatic tick();
    if (rst_n && inst_valid_o && !stall && !jump) pop_log.push_back(inst_pc_o);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (!mem_req_o) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == 1) req_log.push_back(mem_addr_o);
      if (cnt == 2) begin
        mem_ack  = 1'b1;
        mem_data = data_of(mem_addr_o);
      end
    end
  endtask

  task automatic do_reset(input logic stall_v);
    rst_n = 1'b0; stall = stall_v; jump = 1'b0; jump_addr = '0;
    mem_ack = 1'b0; mem_data = '0; cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete(); pop_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_new_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (mem_req_o && cnt == 1) found = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (inst_valid_o) found = 1'b1;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cnt = 0;
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0;
    mem_ack = 1'b0; mem_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   mem_req_o,    32'd0);
    check("rst_addr",  mem_addr_o,   32'd0);
    check("rst_valid", inst_valid_o, 32'd0);
    check("rst_pc",    inst_pc_o,    32'd0);
    check("rst_inst",  inst_o,       32'd0);
    check("rst_pred",  inst_pred_o,  32'd0);

    // Free-running fetch with a consumer that never stalls
    do_reset(1'b0);
    repeat (24) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_req%0d", i),
            (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF, 32'(i * 4));
      check($sformatf("seq_pop%0d", i),
            (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));
    end

    // Stalled consumer: queue fills to 4 and fetch stops
    do_reset(1'b1);
    repeat (20) tick();
    check("full_nreq",  32'(req_log.size()), 32'd4);
    check("full_req",   mem_req_o,    32'd0);
    check("full_valid", inst_valid_o, 32'd1);
    check("full_pc",    inst_pc_o,    32'h0);
    check("full_inst",  inst_o,       32'hC0DE_0000);
    check("full_pred",  inst_pred_o,  32'd0);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check("pop1_pc", inst_pc_o, 32'h4);
    tick();
    check("refill_req",  mem_req_o,  32'd1);
    check("refill_addr", mem_addr_o, 32'h10);

    // Redirect while waiting on 0x8: the 0x8 word is dropped
    do_reset(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (mem_req_o && cnt == 1 && mem_addr_o == 32'h8) ok = 1'b1;
    end
    check("drop_seen8", 32'(ok), 32'd1);
    jump = 1'b1; jump_addr = 32'h103;
    tick();
    jump = 1'b0;
    check("drop_valid", inst_valid_o, 32'd0);
    check("drop_hold",  mem_req_o,    32'd1);
    check("drop_addr",  mem_addr_o,   32'h8);
    wait_new_req(ok);
    check("drop_newreq", 32'(ok), 32'd1);
    check("drop_target", mem_addr_o, 32'h100);
    wait_valid(ok);
    check("drop_gotv", 32'(ok), 32'd1);
    check("drop_head", inst_pc_o, 32'h100);
    check("drop_inst", inst_o,    32'hC0DE_0100);

    // Redirect on the same edge as an ack
    do_reset(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (mem_ack && mem_addr_o == 32'h4) ok = 1'b1;
    end
    check("coin_seenack", 32'(ok), 32'd1);
    jump = 1'b1; jump_addr = 32'h200;
    tick();
    jump = 1'b0;
    check("coin_req",   mem_req_o,    32'd0);
    check("coin_valid", inst_valid_o, 32'd0);
    wait_new_req(ok);
    check("coin_newreq", 32'(ok), 32'd1);
    check("coin_target", mem_addr_o, 32'h200);
    wait_valid(ok);
    check("coin_gotv", 32'(ok), 32'd1);
    check("coin_head", inst_pc_o, 32'h200);

    // Asynchronous reset in the middle of a request
    do_reset(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (mem_req_o && cnt == 1 && mem_addr_o == 32'h4) ok = 1'b1;
    end
    check("arst_seen4", 32'(ok), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   mem_req_o,    32'd0);
    check("arst_addr",  mem_addr_o,   32'd0);
    check("arst_valid", inst_valid_o, 32'd0);
    check("arst_pc",    inst_pc_o,    32'd0);
    mem_ack = 1'b0; cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_new_req(ok);
    check("arst_newreq",  32'(ok), 32'd1);
    check("arst_restart", mem_addr_o, 32'h0);

    // JAL at 0x20 (reached through a redirect issued in IDLE)
    do_reset(1'b1);
    jump = 1'b1; jump_addr = 32'h20;
    tick();
    jump = 1'b0;
    check("jal_idle", mem_req_o, 32'd0);
    wait_new_req(ok);
    check("jal_req0", 32'(ok), 32'd1);
    check("jal_addr0", mem_addr_o, 32'h20);
    wait_new_req(ok);
    check("jal_req1", 32'(ok), 32'd1);
`ifdef JAL_PREDICT_EN
    check("jal_next", mem_addr_o,  32'h30);
    check("jal_pred", inst_pred_o, 32'd1);
`else
    check("jal_next", mem_addr_o,  32'h24);
    check("jal_pred", inst_pred_o, 32'd0);
`endif
    check("jal_head", inst_pc_o, 32'h20);
    check("jal_inst", inst_o,    32'h0100_006F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
